// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered occupancy count,
// almost-full / almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high (overrides wr/rd/clr_err)
//   wr, datin   write request and write data
//   rd          read request (pop)
//   clr_err     clears ovf/udf (a new error on the same edge wins)
//   datout      read data (registered when FWFT=0, live head when FWFT=1)
//   datout_vld  FWFT=0: 1-cycle pulse after an accepted read
//               FWFT=1: head word on datout is valid (= dato)
//   full, empy, dato, afull, aempty   decodes of the registered cont
//   cont        occupancy, 0..DEPTH
//   ovf, udf    sticky error flags: rejected write / rejected read
//
// Parameters must satisfy 0 <= AE_LEVEL < AF_LEVEL <= 2**FIFO_LENGTH.
module sync_fifo_flags #(
  parameter int DATO_WIDTH  = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 2,
  parameter int FWFT        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [DATO_WIDTH-1:0]  datin,
  input  logic                   rd,
  input  logic                   clr_err,
  output logic [DATO_WIDTH-1:0]  datout,
  output logic                   datout_vld,
  output logic                   full,
  output logic                   empy,
  output logic                   dato,
  output logic                   afull,
  output logic                   aempty,
  output logic [FIFO_LENGTH:0]   cont,
  output logic                   ovf,
  output logic                   udf
);

  localparam int DEPTH = 1 << FIFO_LENGTH;
  localparam logic [FIFO_LENGTH:0] DEPTH_C = (FIFO_LENGTH+1)'(DEPTH);
  localparam logic [FIFO_LENGTH:0] AF_C    = (FIFO_LENGTH+1)'(AF_LEVEL);
  localparam logic [FIFO_LENGTH:0] AE_C    = (FIFO_LENGTH+1)'(AE_LEVEL);

  logic [DATO_WIDTH-1:0]  mem [DEPTH];
  logic [FIFO_LENGTH-1:0] wptr;
  logic [FIFO_LENGTH-1:0] rptr;
  logic                   rd_acc;
  logic                   wr_acc;

  // Flags decode the registered count, so they settle one cycle after
  // the accepting edge.
  assign empy   = (cont == '0);
  assign dato   = ~empy;
  assign full   = (cont == DEPTH_C);
  assign afull  = (cont >= AF_C);
  assign aempty = (cont <= AE_C);

  // A full FIFO still takes a write when a read frees a slot on the same
  // edge; an empty FIFO never bypasses datin to a read.
  assign rd_acc = rd & ~empy;
  assign wr_acc = wr & (~full | rd_acc);

  // Memory is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= datin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cont <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      cont <= cont + {{FIFO_LENGTH{1'b0}}, wr_acc} - {{FIFO_LENGTH{1'b0}}, rd_acc};
      // Setting has priority over clearing so an error coincident with
      // clr_err is not lost.
      if (wr && !wr_acc)  ovf <= 1'b1;
      else if (clr_err)   ovf <= 1'b0;
      if (rd && !rd_acc)  udf <= 1'b1;
      else if (clr_err)   udf <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATO_WIDTH-1:0] dout_q;
      logic                  vld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rptr];
        end
      end

      assign datout     = dout_q;
      assign datout_vld = vld_q;
    end else begin : g_fwft
      // Head word is shown continuously; rd consumes it.
      assign datout     = mem[rptr];
      assign datout_vld = dato;
    end
  endgenerate

endmodule
